imm_extend_unit: RTL

Parametrised, registered immediate-generation unit for the 16-bit datapath. Accepts a narrow immediate field from decode and produces a full-width operand using sign-extend, zero-extend or upper-placement modes. Supports a two-instruction prefix sequence that concatenates a held upper part with the next immediate. Sits between the decoder and the operand mux, with a valid/ready handshake on both sides.

---
 rtl/imm_extend_unit.sv | 111 +++++++++++
 1 files changed

// File: rtl/imm_extend_unit.sv
// Registered immediate extender: sign/zero/upper modes plus an optional prefix+suffix concatenation.
// The prefix path is built only when IMM_PREFIX_EN is defined; otherwise mode 11 acts as sign-extend.
module imm_extend_unit #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm_in,
  input  logic [1:0]       mode,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] imm_out,
  output logic             prefix_pending
);
  localparam int PW   = OUT_W - IN_W;
  localparam int MINW = (IN_W < PW) ? IN_W : PW;

  logic             ov_q, ov_d;
  logic [OUT_W-1:0] imm_q, imm_d;
  logic [OUT_W-1:0] zext, ext_res, cat_res;
  logic             accept, is_pfx, held;

  assign in_ready  = !ov_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = ov_q;
  assign imm_out   = imm_q;
  assign zext      = {{PW{1'b0}}, imm_in};

  always_comb begin
    case (mode)
      2'b01:   ext_res = zext;
      2'b10:   ext_res = zext << PW;
      default: ext_res = {{PW{imm_in[IN_W-1]}}, imm_in};
    endcase
  end

`ifdef IMM_PREFIX_EN
  typedef enum logic {IDLE, HELD} state_e;
  state_e          state_q, state_d;
  logic [PW-1:0]   pfx_q, pfx_d, pfx_new;

  assign is_pfx         = (mode == 2'b11);
  assign held           = (state_q == HELD);
  assign prefix_pending = held;
  assign cat_res        = {pfx_q, imm_in};

  always_comb begin
    pfx_new             = '0;
    pfx_new[MINW-1:0]   = imm_in[MINW-1:0];
  end

  always_comb begin
    state_d = state_q;
    pfx_d   = pfx_q;
    if (flush) begin
      state_d = IDLE;
      pfx_d   = '0;
    end else if (accept && is_pfx) begin
      state_d = HELD;
      pfx_d   = pfx_new;
    end else if (accept) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pfx_q   <= '0;
    end else begin
      state_q <= state_d;
      pfx_q   <= pfx_d;
    end
  end
`else
  assign is_pfx         = 1'b0;
  assign held           = 1'b0;
  assign prefix_pending = 1'b0;
  assign cat_res        = ext_res;
`endif

  // A prefix accept with a full output register implies out_ready, so the result drains.
  always_comb begin
    ov_d  = ov_q;
    imm_d = imm_q;
    if (flush) begin
      ov_d = 1'b0;
    end else if (accept && is_pfx) begin
      ov_d = ov_q && !out_ready;
    end else if (accept) begin
      ov_d  = 1'b1;
      imm_d = held ? cat_res : ext_res;
    end else if (out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q  <= 1'b0;
      imm_q <= '0;
    end else begin
      ov_q  <= ov_d;
      imm_q <= imm_d;
    end
  end
endmodule
